// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch_queue prefetching instruction fetcher.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int ENTRY_XLEN  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request bus plus decode-side valid/ready handshake of fetch_queue.
interface fetch_queue_if #(
  parameter int XLEN        = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   queue_count;

  modport master (
    output imem_addr, imem_req, out_valid, out_instr, out_pc, queue_count,
    input  imem_ack, imem_rdata, out_ready
  );

  modport slave (
    input  imem_addr, imem_req, out_valid, out_instr, out_pc, queue_count,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a registered head entry that
// is valid the cycle after the first write into an empty queue.
module fetch_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic                         head_vld,
  output logic [DATA_W-1:0]            head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]     count_q, count_next;
  logic              head_from_wdata;

  always_comb begin
    count_next      = count_q + CW'(push) - CW'(pop);
    rd_next         = rd_ptr + AW'(pop);
    // Only the entry being written this cycle will remain: bypass the array.
    head_from_wdata = (count_q == CW'(pop));
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      head_vld  <= 1'b0;
      head_data <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      head_vld <= 1'b0;
    end else begin
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_ptr + AW'(push);
      count_q  <= count_next;
      head_vld <= (count_next != '0);
      if (count_next != '0)
        head_data <= head_from_wdata ? wdata : mem[rd_next];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetcher: request FSM to instruction memory feeding a
// prefetch FIFO towards decode. Define FETCH_PERF_EN to add perf counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] PC_RESET    = '0,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_change_pc,
  input  logic [XLEN-1:0] wb_next_pc,
  input  logic            ex_change_pc,
  input  logic [XLEN-1:0] ex_next_pc,
  fetch_queue_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_discard_count,
  output logic [31:0]     perf_empty_cycles
`endif
);
  localparam int              CW   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic              redirect;
  logic [XLEN-1:0]   target;
  logic              push, pop;
  logic              head_vld;
  logic [2*XLEN-1:0] head_data;
  logic [2*XLEN-1:0] wdata;
  logic [CW-1:0]     count;
  logic [CW:0]       fill_after;

  always_comb begin
    redirect   = wb_change_pc | ex_change_pc;
    target     = wb_change_pc ? wb_next_pc : ex_next_pc;
    pop        = head_vld & bus.out_ready;
    fill_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
    wdata      = {addr_q, bus.imem_rdata};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d = WAIT;
          addr_d  = target;
        end else if (count < CW'(QUEUE_DEPTH)) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_ack) begin
          if (redirect) begin
            addr_d = target;
          end else begin
            push   = 1'b1;
            addr_d = addr_q + STEP;
            // Only keep requesting if the response is guaranteed a free slot.
            if (fill_after >= (CW+1)'(QUEUE_DEPTH)) state_d = IDLE;
          end
        end else if (redirect) begin
          state_d = DISCARD;
          pend_d  = target;
        end
      end
      DISCARD: begin
        if (bus.imem_ack) begin
          state_d = WAIT;
          addr_d  = redirect ? target : pend_q;
        end else if (redirect) begin
          pend_d = target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= PC_RESET;
      pend_q  <= PC_RESET;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
    end
  end

  // Stage boundary: memory response -> prefetch queue -> decode
  fetch_fifo #(
    .DATA_W (2*XLEN),
    .DEPTH  (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .wdata     (wdata),
    .pop       (pop),
    .head_vld  (head_vld),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.imem_req    = (state_q != IDLE);
  assign bus.imem_addr   = addr_q;
  assign bus.out_valid   = head_vld;
  assign bus.out_pc      = head_data[2*XLEN-1:XLEN];
  assign bus.out_instr   = head_data[XLEN-1:0];
  assign bus.queue_count = count;

`ifdef FETCH_PERF_EN
  logic drop;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  // A response is dropped when it lands with a redirect or after one.
  assign drop = bus.imem_ack & (((state_q == WAIT) & redirect) | (state_q == DISCARD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_discard_count <= '0;
      perf_empty_cycles  <= '0;
    end else begin
      perf_discard_count <= sat_inc(perf_discard_count, drop);
      perf_empty_cycles  <= sat_inc(perf_empty_cycles, !head_vld && bus.out_ready);
    end
  end
`endif

endmodule
